ql_matrix_encoder: RTL and testbench

Reverse path of the PS/2-to-QL keyboard mapper. It scans a 64-bit QL key matrix and emits one PS/2 set-2 key event per changed matrix position, in the same 11-bit `ps2_key` word format the mapper consumes. It sits between any matrix-producing source (on-screen keyboard, IPC model, test bench) and the existing `keyboard` block or the host event path, and spaces events so combined modifier keys arrive modifier-first.

---
 rtl/ql_matrix_encoder.sv | 119 +++++++++++
 tb/tb_ql_matrix_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ql_matrix_encoder.sv
// rtl/ql_matrix_encoder.sv - QL key matrix scanner emitting PS/2 set-2 key events
module ql_matrix_encoder #(
  parameter int unsigned MIN_GAP = 16,
  parameter bit          EXT_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        delay_reset,
  input  logic        ce_11m,
  input  logic        enable,
  input  logic [63:0] matrix,
  output logic [10:0] ps2_key,
  output logic        busy
);

  typedef enum logic {
    SCAN = 1'b0,
    GAP  = 1'b1
  } state_t;

  // GAP holds for MIN_GAP ce edges: MIN_GAP-1 decrements plus the exit edge.
  localparam logic [7:0] GAP_RELOAD = 8'(MIN_GAP - 1);
  localparam logic [5:0] SCAN_START = 6'd56;

  state_t      state_q, state_d;
  logic [63:0] prev_q, prev_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [10:0] key_q, key_d;
  logic        cur_bit;

  // Set-2 scancode for each matrix position (bit index = 8*row + col).
  function automatic logic [7:0] scan_code(input logic [5:0] pos);
    logic [7:0] code;
    case (pos)
      6'd0:  code = 8'h0C;  6'd1:  code = 8'h05;  6'd2:  code = 8'h2E;  6'd3:  code = 8'h06;
      6'd4:  code = 8'h04;  6'd5:  code = 8'h03;  6'd6:  code = 8'h25;  6'd7:  code = 8'h3D;
      6'd8:  code = 8'h5A;  6'd9:  code = 8'h6B;  6'd10: code = 8'h75;  6'd11: code = 8'h76;
      6'd12: code = 8'h74;  6'd13: code = 8'h5D;  6'd14: code = 8'h29;  6'd15: code = 8'h72;
      6'd16: code = 8'h5B;  6'd17: code = 8'h1A;  6'd18: code = 8'h49;  6'd19: code = 8'h21;
      6'd20: code = 8'h32;  6'd21: code = 8'h61;  6'd22: code = 8'h3A;  6'd23: code = 8'h52;
      6'd24: code = 8'h54;  6'd25: code = 8'h58;  6'd26: code = 8'h42;  6'd27: code = 8'h1B;
      6'd28: code = 8'h2B;  6'd29: code = 8'h55;  6'd30: code = 8'h34;  6'd31: code = 8'h4C;
      6'd32: code = 8'h4B;  6'd33: code = 8'h26;  6'd34: code = 8'h33;  6'd35: code = 8'h16;
      6'd36: code = 8'h1C;  6'd37: code = 8'h4D;  6'd38: code = 8'h23;  6'd39: code = 8'h3B;
      6'd40: code = 8'h46;  6'd41: code = 8'h1D;  6'd42: code = 8'h43;  6'd43: code = 8'h0D;
      6'd44: code = 8'h2D;  6'd45: code = 8'h4E;  6'd46: code = 8'h35;  6'd47: code = 8'h44;
      6'd48: code = 8'h3E;  6'd49: code = 8'h1E;  6'd50: code = 8'h36;  6'd51: code = 8'h15;
      6'd52: code = 8'h24;  6'd53: code = 8'h45;  6'd54: code = 8'h2C;  6'd55: code = 8'h3C;
      6'd56: code = 8'h12;  6'd57: code = 8'h14;  6'd58: code = 8'h11;  6'd59: code = 8'h22;
      6'd60: code = 8'h2A;  6'd61: code = 8'h4A;  6'd62: code = 8'h31;  6'd63: code = 8'h41;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  // Cursor keys (Left, Up, Right, Down) live in row 1 and carry the E0 prefix.
  function automatic logic is_cursor(input logic [5:0] pos);
    return (pos == 6'd9) || (pos == 6'd10) || (pos == 6'd12) || (pos == 6'd15);
  endfunction

  assign cur_bit = matrix[idx_q];

  // Next-state: compare one position per ce edge in SCAN, count down in GAP.
  // The plain 6-bit increment gives the 63->0 and 55->56 wraps, so starting at
  // 56 puts the modifier row first in every pass.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    key_d     = key_q;
    if (ce_11m) begin
      case (state_q)
        SCAN: begin
          if (enable) begin
            if (cur_bit == prev_q[idx_q]) begin
              idx_d = idx_q + 6'd1;
            end else begin
              prev_d[idx_q] = cur_bit;
              key_d         = {~key_q[10], cur_bit, EXT_MAP && is_cursor(idx_q), scan_code(idx_q)};
              gap_cnt_d     = GAP_RELOAD;
              state_d       = GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 8'd0) begin
            idx_d   = idx_q + 6'd1;
            state_d = SCAN;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State registers, cleared asynchronously so a reset aborts GAP without a clock.
  always_ff @(posedge clk or posedge delay_reset) begin
    if (delay_reset) begin
      state_q   <= SCAN;
      prev_q    <= '0;
      idx_q     <= SCAN_START;
      gap_cnt_q <= '0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      key_q     <= key_d;
    end
  end

  assign ps2_key = key_q;
  assign busy    = (state_q == GAP);

endmodule

// File: tb/tb_ql_matrix_encoder.sv
// tb/tb_ql_matrix_encoder.sv - scoreboard bench for ql_matrix_encoder
module tb_ql_matrix_encoder;

  localparam int MIN_GAP = 16;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        delay_reset;
  logic        ce;
  logic        enable;
  logic [63:0] matrix;
  logic [10:0] ps2_a, ps2_b;
  logic        busy_a, busy_b;

  ql_matrix_encoder #(.MIN_GAP(MIN_GAP), .EXT_MAP(1'b1)) dut_a (
    .clk(clk), .delay_reset(delay_reset), .ce_11m(ce), .enable(enable),
    .matrix(matrix), .ps2_key(ps2_a), .busy(busy_a)
  );

  ql_matrix_encoder #(.MIN_GAP(MIN_GAP), .EXT_MAP(1'b0)) dut_b (
    .clk(clk), .delay_reset(delay_reset), .ce_11m(ce), .enable(enable),
    .matrix(matrix), .ps2_key(ps2_b), .busy(busy_b)
  );

  always #5 if (clk_en) clk = ~clk;

  logic [7:0] key_code [64] = '{
    8'h0C, 8'h05, 8'h2E, 8'h06, 8'h04, 8'h03, 8'h25, 8'h3D,
    8'h5A, 8'h6B, 8'h75, 8'h76, 8'h74, 8'h5D, 8'h29, 8'h72,
    8'h5B, 8'h1A, 8'h49, 8'h21, 8'h32, 8'h61, 8'h3A, 8'h52,
    8'h54, 8'h58, 8'h42, 8'h1B, 8'h2B, 8'h55, 8'h34, 8'h4C,
    8'h4B, 8'h26, 8'h33, 8'h16, 8'h1C, 8'h4D, 8'h23, 8'h3B,
    8'h46, 8'h1D, 8'h43, 8'h0D, 8'h2D, 8'h4E, 8'h35, 8'h44,
    8'h3E, 8'h1E, 8'h36, 8'h15, 8'h24, 8'h45, 8'h2C, 8'h3C,
    8'h12, 8'h14, 8'h11, 8'h22, 8'h2A, 8'h4A, 8'h31, 8'h41
  };

  int n_pass = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic ext_code(input logic [7:0] code);
    return (code == 8'h75) || (code == 8'h72) || (code == 8'h6B) || (code == 8'h74);
  endfunction

  // Reference model: scan position counts along the pass (position 0 = key 56),
  // GAP is a count of remaining ce pulses before the next compare.
  logic [63:0] m_prev;
  int          m_pos;
  int          m_gap;
  logic        m_tog;
  int          ce_cnt = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  always @(posedge clk or posedge delay_reset) begin
    int         k;
    logic [7:0] code;
    if (delay_reset) begin
      m_prev = '0;
      m_pos  = 0;
      m_gap  = 0;
      m_tog  = 1'b0;
    end else if (ce) begin
      ce_cnt++;
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) m_pos = (m_pos + 1) % 64;
      end else if (enable) begin
        k = (m_pos + 56) % 64;
        if (matrix[k] != m_prev[k]) begin
          m_prev[k] = matrix[k];
          m_tog     = ~m_tog;
          code      = key_code[k];
          q_a.push_back({m_tog, matrix[k], ext_code(code), code});
          q_b.push_back({m_tog, matrix[k], 1'b0, code});
          m_gap = MIN_GAP;
        end else begin
          m_pos = (m_pos + 1) % 64;
        end
      end
    end
  end

  // Monitor: every event the model emitted must appear on the following
  // negedge; otherwise the outputs must hold.
  logic [10:0] last_a, last_b;
  logic [10:0] ev_a[$];
  logic [10:0] ev_b[$];
  int          ev_t[$];

  always @(negedge clk or posedge delay_reset) begin
    logic [10:0] e;
    if (delay_reset) begin
      q_a.delete();
      q_b.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      check("busy_a", 32'(busy_a), 32'(m_gap > 0));
      check("busy_b", 32'(busy_b), 32'(m_gap > 0));
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("event_a", 32'(ps2_a), 32'(e));
        last_a = e;
        ev_a.push_back(ps2_a);
        ev_t.push_back(ce_cnt);
      end else begin
        check("hold_a", 32'(ps2_a), 32'(last_a));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("event_b", 32'(ps2_b), 32'(e));
        last_b = e;
        ev_b.push_back(ps2_b);
      end else begin
        check("hold_b", 32'(ps2_b), 32'(last_b));
      end
    end
  end

  function automatic logic [10:0] ev_at(input int i, input bit from_b);
    if (from_b) return (i < ev_b.size()) ? ev_b[i] : 11'h7FF;
    return (i < ev_a.size()) ? ev_a[i] : 11'h7FF;
  endfunction

  task automatic ev_clear();
    ev_a.delete();
    ev_b.delete();
    ev_t.delete();
  endtask

  task automatic run_ce(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      ce = ($urandom_range(0, 3) != 0);
      if (ce) k++;
    end
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle(input string name);
    int b = 0;
    while ((matrix != m_prev || m_gap != 0) && b < 20000) begin
      @(negedge clk);
      ce = ($urandom_range(0, 3) != 0);
      b++;
    end
    run_ce(2);
    check(name, 32'(b < 20000), 32'd1);
  endtask

  task automatic wait_scan_start();
    int b = 0;
    forever begin
      @(negedge clk);
      if ((m_pos == 0 && m_gap == 0) || b >= 500) break;
      ce = 1'b1;
      b++;
    end
    check("reach_pos56", 32'(b < 500), 32'd1);
  endtask

  initial begin
    int picks[$];
    int r;
    int min_gap;
    bit distinct;
    ce = 1'b0;
    enable = 1'b1;
    matrix = '0;
    delay_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_key", 32'(ps2_a), 32'h0);
    check("reset_busy", 32'(busy_a), 32'h0);
    delay_reset = 1'b0;

    // Idle matrix produces nothing.
    ev_clear();
    run_ce(300);
    check("idle_key", 32'(ps2_a), 32'h0);
    check("idle_busy", 32'(busy_a), 32'h0);
    check("idle_events", 32'(ev_a.size()), 32'd0);

    // Single key press and release.
    ev_clear();
    matrix[36] = 1'b1;
    settle("settle_a_press");
    check("a_press", 32'(ev_at(0, 0)), 32'h61C);
    ev_clear();
    matrix[36] = 1'b0;
    settle("settle_a_release");
    check("a_release", 32'(ev_at(0, 0)), 32'h01C);

    // Ctrl+Left together: modifier first, extended flag only when enabled.
    ev_clear();
    wait_scan_start();
    matrix[57] = 1'b1;
    matrix[9]  = 1'b1;
    settle("settle_ctrl_left");
    check("ctrl_first", 32'(ev_at(0, 0)), 32'h614);
    check("left_ext", 32'(ev_at(1, 0)), 32'h36B);
    check("left_noext", 32'(ev_at(1, 1)), 32'h26B);
    check("ctrl_left_gap", 32'((ev_t.size() >= 2) && (ev_t[1] - ev_t[0] >= MIN_GAP + 1)), 32'd1);
    matrix[57] = 1'b0;
    matrix[9]  = 1'b0;
    settle("settle_ctrl_left_rel");

    // Eight keys at once.
    ev_clear();
    picks.delete();
    while (picks.size() < 8) begin
      r = $urandom_range(0, 63);
      if (!matrix[r]) begin
        matrix[r] = 1'b1;
        picks.push_back(r);
      end
    end
    settle("settle_eight");
    check("eight_count", 32'(ev_a.size()), 32'd8);
    distinct = 1'b1;
    min_gap = 1000000;
    for (int i = 0; i < ev_a.size(); i++) begin
      for (int j = 0; j < i; j++) if (ev_a[i][7:0] == ev_a[j][7:0]) distinct = 1'b0;
      if (i > 0 && ev_t[i] - ev_t[i-1] < min_gap) min_gap = ev_t[i] - ev_t[i-1];
    end
    check("eight_distinct", 32'(distinct), 32'd1);
    check("eight_min_gap", 32'(min_gap >= MIN_GAP + 1), 32'd1);
    matrix = '0;
    settle("settle_eight_rel");

    // Reset in the middle of GAP with the clock stopped.
    matrix[7] = 1'b1;
    begin
      int b = 0;
      while (!busy_a && b < 200) begin
        @(negedge clk);
        ce = 1'b1;
        b++;
      end
    end
    check("gap_reached", 32'(busy_a), 32'd1);
    repeat (3) @(negedge clk);
    ce = 1'b0;
    clk_en = 1'b0;
    #23 delay_reset = 1'b1;
    #1;
    check("async_rst_key", 32'(ps2_a), 32'h0);
    check("async_rst_busy", 32'(busy_a), 32'h0);
    ev_clear();
    #11 delay_reset = 1'b0;
    #7 clk_en = 1'b1;
    settle("settle_after_reset");
    check("rereport_7", 32'(ev_at(0, 0)), 32'h63D);
    matrix[7] = 1'b0;
    settle("settle_7_rel");

    // Enable low freezes the scan.
    ev_clear();
    enable = 1'b0;
    matrix[0] = 1'b1;
    run_ce(200);
    check("disabled_events", 32'(ev_a.size()), 32'd0);
    enable = 1'b1;
    settle("settle_enable");
    check("enabled_f4", 32'(ev_at(0, 0)), 32'h60C);
    matrix[0] = 1'b0;
    settle("settle_f4_rel");

    // Random matrix activity with random enable.
    for (int it = 0; it < 60; it++) begin
      for (int f = 0; f < $urandom_range(1, 3); f++) begin
        r = $urandom_range(0, 63);
        matrix[r] = ~matrix[r];
      end
      enable = ($urandom_range(0, 7) != 0);
      run_ce($urandom_range(0, 60));
    end
    enable = 1'b1;
    settle("settle_random");
    check("final_busy", 32'(busy_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
